// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared pipeline types and widths for the memory stage
package mem_wb_stage_pkg;

    localparam int WORD_W          = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

endpackage

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - data-memory handshake FSM with timeout abort
module mem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic memOp,
    input  logic misaligned,
    input  logic dmemReady,
    output logic dmemReq,
    output logic memStall,
    output logic accessDone,
    output logic accessAbort
);

    memState_t        state;
    logic [CNT_W-1:0] waitCnt;

    // Only IDLE and WAIT exist, so any aligned memory op requests; reset masks it.
    assign dmemReq     = rst & memOp & ~misaligned;
    assign accessAbort = rst & (state == WAIT) & ~dmemReady
                         & (waitCnt == CNT_W'(TIMEOUT - 1));
    assign accessDone  = dmemReq & dmemReady;
    assign memStall    = dmemReq & ~dmemReady & ~accessAbort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmemReq && !dmemReady) begin
                        state   <= WAIT;
                        waitCnt <= '0;
                    end
                end
                WAIT: begin
                    if (dmemReady || accessAbort) begin
                        state <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage and MEM/WB pipeline register
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EX_MEM_RegWrite,
    input  logic                  EX_MEM_MemtoReg,
    input  logic                  EX_MEM_MemRead,
    input  logic                  EX_MEM_MemWrite,
    input  logic [WORD_W-1:0]     DataMemoryAddress,
    input  logic [WORD_W-1:0]     DataMemoryWriteData,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic [WORD_W-1:0]     dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  MEM_Stall,
    output logic                  MEM_WB_RegWrite,
    output logic                  MEM_WB_MemtoReg,
    output logic [WORD_W-1:0]     MEM_WB_ReadData,
    output logic [WORD_W-1:0]     MEM_WB_ALUResult,
    output logic [REG_ADDR_W-1:0] MEM_WB_RegisterRd,
    output logic                  MEM_AddrErr,
    output logic                  MEM_BusErr
);

    logic memOp;
    logic misaligned;
    logic accessDone;
    logic accessAbort;
    logic loadDone;

    assign memOp      = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign misaligned = memOp & (DataMemoryAddress[1:0] != 2'b00);
    // A simultaneous read+write is a store, so the load path stays quiet.
    assign loadDone   = accessDone & EX_MEM_MemRead & ~EX_MEM_MemWrite;

    assign dmem_we    = EX_MEM_MemWrite;
    assign dmem_addr  = DataMemoryAddress;
    assign dmem_wdata = DataMemoryWriteData;

    mem_access_fsm #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .memOp       (memOp),
        .misaligned  (misaligned),
        .dmemReady   (dmem_ready),
        .dmemReq     (dmem_req),
        .memStall    (MEM_Stall),
        .accessDone  (accessDone),
        .accessAbort (accessAbort)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_MemtoReg   <= 1'b0;
            MEM_WB_ReadData   <= '0;
            MEM_WB_ALUResult  <= '0;
            MEM_WB_RegisterRd <= '0;
            MEM_AddrErr       <= 1'b0;
            MEM_BusErr        <= 1'b0;
        end else begin
            MEM_AddrErr <= 1'b0;
            MEM_BusErr  <= 1'b0;
            if (MEM_Stall || misaligned || accessAbort) begin
                // Bubble: faulted or pending accesses must never write the register file.
                MEM_WB_RegWrite <= 1'b0;
                MEM_WB_MemtoReg <= 1'b0;
                MEM_AddrErr     <= misaligned;
                MEM_BusErr      <= accessAbort;
            end else begin
                MEM_WB_RegWrite   <= EX_MEM_RegWrite;
                MEM_WB_MemtoReg   <= EX_MEM_MemtoReg;
                MEM_WB_ALUResult  <= DataMemoryAddress;
                MEM_WB_RegisterRd <= EX_MEM_RegisterRd;
                if (loadDone) begin
                    MEM_WB_ReadData <= dmem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for the memory stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        exRegWrite, exMemtoReg, exMemRead, exMemWrite;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd;
    logic        ready;
    logic        dmemReq, dmemWe, stall;
    logic [31:0] dmemAddr, dmemWdata;
    logic        wbRegWrite, wbMemtoReg, addrErr, busErr;
    logic [31:0] wbReadData, wbAlu;
    logic [4:0]  wbRd;

    int passCnt  = 0;
    int totalCnt = 0;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        ae;
        logic        be;
    } wb_t;

    wb_t sbq[$];

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .EX_MEM_RegWrite     (exRegWrite),
        .EX_MEM_MemtoReg     (exMemtoReg),
        .EX_MEM_MemRead      (exMemRead),
        .EX_MEM_MemWrite     (exMemWrite),
        .DataMemoryAddress   (addr),
        .DataMemoryWriteData (wdata),
        .EX_MEM_RegisterRd   (rd),
        .dmem_req            (dmemReq),
        .dmem_we             (dmemWe),
        .dmem_addr           (dmemAddr),
        .dmem_wdata          (dmemWdata),
        .dmem_rdata          (rdata),
        .dmem_ready          (ready),
        .MEM_Stall           (stall),
        .MEM_WB_RegWrite     (wbRegWrite),
        .MEM_WB_MemtoReg     (wbMemtoReg),
        .MEM_WB_ReadData     (wbReadData),
        .MEM_WB_ALUResult    (wbAlu),
        .MEM_WB_RegisterRd   (wbRd),
        .MEM_AddrErr         (addrErr),
        .MEM_BusErr          (busErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic setIn(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        exRegWrite = rw;
        exMemtoReg = m2r;
        exMemRead  = mr;
        exMemWrite = mw;
        addr       = a;
        wdata      = wd;
        rd         = r;
    endtask

    task automatic expect_wb(input logic rw, input logic m2r, input logic [31:0] rdv,
                             input logic [31:0] alu, input logic [4:0] r,
                             input logic ae, input logic be);
        wb_t e;
        e.rw = rw; e.m2r = m2r; e.rdata = rdv; e.alu = alu; e.rd = r; e.ae = ae; e.be = be;
        sbq.push_back(e);
    endtask

    task automatic checkWb(input string tag);
        wb_t e;
        if (sbq.size() == 0) begin
            totalCnt++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, ".RegWrite"},  32'(wbRegWrite), 32'(e.rw));
        chk({tag, ".MemtoReg"},  32'(wbMemtoReg), 32'(e.m2r));
        chk({tag, ".ReadData"},  wbReadData,      e.rdata);
        chk({tag, ".ALUResult"}, wbAlu,           e.alu);
        chk({tag, ".Rd"},        32'(wbRd),       32'(e.rd));
        chk({tag, ".AddrErr"},   32'(addrErr),    32'(e.ae));
        chk({tag, ".BusErr"},    32'(busErr),     32'(e.be));
    endtask

    // Inputs are driven at negedge; combinational outputs are checked just after,
    // the registered MEM/WB state just after the following posedge.
    task automatic cycle(input string tag, input logic expReq, input logic expStall);
        #1;
        chk({tag, ".dmem_req"}, 32'(dmemReq), 32'(expReq));
        chk({tag, ".MEM_Stall"}, 32'(stall), 32'(expStall));
        @(posedge clk);
        #1;
        checkWb(tag);
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b0;
        ready = 1'b0;
        rdata = 32'h0;
        setIn(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(negedge clk);
        expect_wb(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        checkWb("reset_initial");
        chk("reset_req", 32'(dmemReq), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        setIn(1, 0, 0, 0, 32'h0000_1234, 32'h0, 5'd7);
        expect_wb(1, 0, 32'h0, 32'h0000_1234, 5'd7, 0, 0);
        cycle("alu_pass", 0, 0);

        setIn(1, 1, 1, 0, 32'h100, 32'h0, 5'd3);
        ready = 1'b1;
        rdata = 32'hDEAD_BEEF;
        expect_wb(1, 1, 32'hDEAD_BEEF, 32'h100, 5'd3, 0, 0);
        cycle("load_zero_wait", 1, 0);

        setIn(0, 0, 0, 1, 32'h200, 32'hA5A5_A5A5, 5'd4);
        ready = 1'b0;
        rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("store_we", 32'(dmemWe), 32'h1);
            chk("store_wdata", dmemWdata, 32'hA5A5_A5A5);
            chk("store_addr", dmemAddr, 32'h200);
            expect_wb(0, 0, 32'hDEAD_BEEF, 32'h100, 5'd3, 0, 0);
            cycle("store_wait", 1, 1);
        end
        ready = 1'b1;
        #1;
        chk("store_we_done", 32'(dmemWe), 32'h1);
        expect_wb(0, 0, 32'hDEAD_BEEF, 32'h200, 5'd4, 0, 0);
        cycle("store_done", 1, 0);

        setIn(1, 1, 1, 0, 32'h102, 32'h0, 5'd9);
        ready = 1'b0;
        expect_wb(0, 0, 32'hDEAD_BEEF, 32'h200, 5'd4, 1, 0);
        cycle("misaligned", 0, 0);
        setIn(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        expect_wb(0, 0, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0);
        cycle("addrerr_pulse_end", 0, 0);

        // TIMEOUT=4: the IDLE issue cycle plus three WAIT cycles stall, the fourth WAIT cycle aborts.
        setIn(1, 1, 1, 0, 32'h300, 32'h0, 5'd5);
        for (int i = 0; i < 4; i++) begin
            expect_wb(0, 0, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0);
            cycle("timeout_wait", 1, 1);
        end
        expect_wb(0, 0, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 1);
        cycle("timeout_abort", 1, 0);
        setIn(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        expect_wb(0, 0, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0);
        cycle("buserr_pulse_end", 0, 0);

        setIn(1, 1, 1, 0, 32'h304, 32'h0, 5'd6);
        rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            expect_wb(0, 0, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0);
            cycle("late_ready_wait", 1, 1);
        end
        ready = 1'b1;
        expect_wb(1, 1, 32'hCAFE_F00D, 32'h304, 5'd6, 0, 0);
        cycle("ready_beats_abort", 1, 0);

        setIn(1, 1, 1, 1, 32'h400, 32'h5555_0000, 5'd8);
        rdata = 32'h2222_2222;
        #1;
        chk("rw_both_we", 32'(dmemWe), 32'h1);
        expect_wb(1, 1, 32'hCAFE_F00D, 32'h400, 5'd8, 0, 0);
        cycle("rw_both_store", 1, 0);

        setIn(1, 1, 1, 0, 32'h500, 32'h0, 5'd10);
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_wb(0, 0, 32'hCAFE_F00D, 32'h400, 5'd8, 0, 0);
            cycle("pre_reset_wait", 1, 1);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(dmemReq), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        expect_wb(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        checkWb("rst_mid_wait");
        setIn(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_wb(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
            cycle("post_reset_idle", 0, 0);
        end

        setIn(1, 1, 1, 0, 32'h600, 32'h0, 5'd11);
        ready = 1'b1;
        rdata = 32'h0BAD_CAFE;
        expect_wb(1, 1, 32'h0BAD_CAFE, 32'h600, 5'd11, 0, 0);
        cycle("post_reset_load", 1, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
